md_sequencer: RTL and testbench

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_pkg.sv | 26 ++
 rtl/md_sequencer_arith.sv | 44 ++++
 rtl/md_sequencer.sv | 91 +++++++++
 tb/tb_md_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared CPU definitions for the multiply/divide unit: md_op codes, default latencies, FSM states.
// Constants and helpers only. There is no logic, latency or backpressure here.
package md_sequencer_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/md_sequencer_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder for the md_op on a/b.
// Zero latency. There is no flow control, and the sequencer samples the outputs when it accepts a start.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    assign div_zero = (b == 32'd0);

    always_comb begin
        prod = '0;
        quot = '0;
        rem  = '0;
        case (md_op)
            MD_MULT:  prod = 64'($signed(a)) * 64'($signed(b));
            MD_MULTU: prod = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                // Most-negative / -1 overflows, so pin the architectural result explicitly.
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    quot = 32'h8000_0000;
                    rem  = 32'd0;
                end else if (!div_zero) begin
                    quot = $signed(a) / $signed(b);
                    rem  = $signed(a) % $signed(b);
                end
            end
            MD_DIVU: begin
                if (!div_zero) begin
                    quot = a / b;
                    rem  = a % b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply-divide sequencer. A result is computed at start and committed after MULT_CYCLES or DIV_CYCLES.
// Latency is N cycles busy and hi/lo update on the Nth edge. It stalls the ID stage while busy, and a start during RUN is dropped.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        id_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   pending_hi;
    logic [31:0]   pending_lo;

    logic [63:0]   prod;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic          div_zero;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    md_arith u_arith (
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    // A divide by zero re-commits the current hi/lo, so the architectural state is left untouched.
    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div(md_op)) begin
            res_hi = div_zero ? hi : rem;
            res_lo = div_zero ? lo : quot;
        end
    end

    assign busy  = (state == ST_RUN);
    assign stall = id_is_md & (busy | (start & is_arith(md_op)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                if (is_arith(md_op)) begin
                    pending_hi <= res_hi;
                    pending_lo <= res_lo;
                    cnt        <= is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state      <= ST_RUN;
                end else if (md_op == MD_MTHI) begin
                    hi <= a;
                end else if (md_op == MD_MTLO) begin
                    lo <= a;
                end
            end
        end else begin
            if (cnt == CW'(1)) begin
                hi    <= pending_hi;
                lo    <= pending_lo;
                state <= ST_IDLE;
            end
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed test of md_sequencer covering latencies, arithmetic results, div-by-zero, stall, ignored start and reset abort.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        id_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    md_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .id_is_md (id_is_md),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    task automatic run_busy(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {31'd0, busy}, 32'd1);
            tick();
        end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_MULT; a = '0; b = '0; id_is_md = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        // MULT -2 * 3 with id_is_md held: stall in start cycle and all busy cycles
        id_is_md = 1'b1;
        start = 1'b1; md_op = MD_MULT; a = 32'hFFFF_FFFE; b = 32'd3;
        #1;
        chk("stall_start", {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mult_busy", {31'd0, busy}, 32'd1);
            chk("mult_stall", {31'd0, stall}, 32'd1);
            chk("mult_hi_hold", hi, 32'd0);
            tick();
        end
        chk("mult_idle", {31'd0, busy}, 32'd0);
        chk("mult_stall_off", {31'd0, stall}, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        id_is_md = 1'b0;

        // no stall when ID is not an md instruction
        start = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd7;
        #1;
        chk("nostall_start", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        chk("nostall_busy", {31'd0, stall}, 32'd0);
        run_busy("divu_busy", 10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        run_busy("div_busy", 10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        launch(MD_MTHI, 32'h11, 32'd0);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        launch(MD_MTLO, 32'h22, 32'd0);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_hi", hi, 32'h11);

        launch(MD_DIV, 32'd1234, 32'd0);
        run_busy("div0_busy", 10);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy("ovf_busy", 10);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        launch(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        chk("mthi2_hi", hi, 32'hDEAD_BEEF);
        chk("mthi2_busy", {31'd0, busy}, 32'd0);

        // undefined op is a no-op
        launch(3'd7, 32'h1234_5678, 32'd9);
        chk("bad_op_busy", {31'd0, busy}, 32'd0);
        chk("bad_op_hi", hi, 32'hDEAD_BEEF);
        chk("bad_op_lo", lo, 32'h8000_0000);

        // MULTU with a second MULT offered at busy cycle 3
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("ign_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_busy3", {31'd0, busy}, 32'd1);
        launch(MD_MULT, 32'd2, 32'd2);
        chk("ign_busy4", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_busy5", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_idle", {31'd0, busy}, 32'd0);
        chk("ign_hi", hi, 32'hFFFF_FFFE);
        chk("ign_lo", lo, 32'h0000_0001);
        tick();
        chk("ign_no_restart", {31'd0, busy}, 32'd0);

        // reset at busy cycle 2 of a DIV aborts it
        launch(MD_DIV, 32'd50, 32'd5);
        chk("abort_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("abort_busy2", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_late_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        // reset wins over a simultaneous start
        reset = 1'b1;
        launch(MD_MTHI, 32'h5, 32'd0);
        reset = 1'b0;
        chk("rst_prio_hi", hi, 32'd0);
        launch(MD_MULT, 32'd3, 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
